// File: rtl/moore_stim_sequencer_if.sv
// -----------------------------------------------------------------------------
// moore_stim_sequencer_if
// Bundles every non-clock, non-reset signal of the stimulus sequencer.
//   Host side    : wr_en/wr_addr/wr_data (script load), num_steps/start (run
//                  request), busy/done (run status), err_count/err_flag/
//                  first_err (run results).
//   Machine side : dut_reset, I, S driven to the Moore machine under test;
//                  Q_1, Q_0 returned from it.
// The master modport is the environment (host plus Moore machine), the slave
// modport is the sequencer itself.
// -----------------------------------------------------------------------------
interface moore_stim_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic [ADDR_W:0]   num_steps;
    logic              start;
    logic              busy;
    logic              done;
    logic              dut_reset;
    logic              I;
    logic              S;
    logic              Q_1;
    logic              Q_0;
    logic [ADDR_W:0]   err_count;
    logic              err_flag;
    logic [ADDR_W-1:0] first_err;

    modport master (
        output wr_en, wr_addr, wr_data, num_steps, start, Q_1, Q_0,
        input  busy, done, dut_reset, I, S, err_count, err_flag, first_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, num_steps, start, Q_1, Q_0,
        output busy, done, dut_reset, I, S, err_count, err_flag, first_err
    );
endinterface

// File: rtl/moore_stim_sequencer.sv
// -----------------------------------------------------------------------------
// moore_stim_sequencer
// Programmable stimulus/check sequencer for a two-input Moore machine.
// A script of DEPTH entries {I, S, expQ_1, expQ_0} is loaded while idle. On
// start the Moore machine is reset for one cycle, then each step drives (I, S)
// for HOLD_CYCLES cycles and compares {Q_1, Q_0} on the last hold cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (script RAM is not cleared)
//   bus  : slave modport of moore_stim_sequencer_if (script load, run
//          control, results, Moore machine stimulus/response)
// All outputs are registered.
// -----------------------------------------------------------------------------
module moore_stim_sequencer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    moore_stim_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RST_DUT,
        APPLY,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      HOLD_END = 8'(HOLD_CYCLES - 1);

    logic [3:0] ram [DEPTH];

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] step_q, step_n;
    logic [7:0]        hold_q, hold_n;
    logic [ADDR_W:0]   steps_q, steps_n;
    logic [ADDR_W:0]   err_count_q, err_count_n;
    logic              err_flag_q, err_flag_n;
    logic [ADDR_W-1:0] first_err_q, first_err_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              dut_reset_q, dut_reset_n;
    logic              i_q, i_n;
    logic              s_q, s_n;

    logic [ADDR_W-1:0] step_plus;
    logic [ADDR_W:0]   steps_clamped;
    logic [3:0]        cur_entry;
    logic [3:0]        next_entry;
    logic [3:0]        first_entry;
    logic              last_step;

    assign step_plus     = step_q + ADDR_W'(1);
    assign steps_clamped = (bus.num_steps > DEPTH_W) ? DEPTH_W : bus.num_steps;
    assign cur_entry     = ram[step_q];
    assign next_entry    = ram[step_plus];
    assign first_entry   = ram[ADDR_W'(0)];
    assign last_step     = ((ADDR_W+1)'(step_q) + (ADDR_W+1)'(1)) == steps_q;

    // Script RAM: only writable while idle so a running script cannot change
    // under the sequencer. Deliberately not reset so a script survives Reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_q == IDLE)) begin
            ram[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so each branch sets what the following cycle must show.
    always_comb begin
        state_n     = state_q;
        step_n      = step_q;
        hold_n      = hold_q;
        steps_n     = steps_q;
        err_count_n = err_count_q;
        err_flag_n  = err_flag_q;
        first_err_n = first_err_q;
        busy_n      = busy_q;
        done_n      = 1'b0;
        dut_reset_n = 1'b0;
        i_n         = i_q;
        s_n         = s_q;

        unique case (state_q)
            IDLE: begin
                busy_n = 1'b0;
                i_n    = 1'b0;
                s_n    = 1'b0;
                if (bus.start) begin
                    state_n     = RST_DUT;
                    steps_n     = steps_clamped;
                    err_count_n = '0;
                    err_flag_n  = 1'b0;
                    first_err_n = '0;
                    busy_n      = 1'b1;
                    dut_reset_n = 1'b1;
                end
            end

            RST_DUT: begin
                step_n = '0;
                hold_n = '0;
                if (steps_q == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = APPLY;
                    i_n     = first_entry[3];
                    s_n     = first_entry[2];
                end
            end

            APPLY: begin
                if (hold_q == HOLD_END) begin
                    hold_n = '0;
                    if ({bus.Q_1, bus.Q_0} != cur_entry[1:0]) begin
                        // err_count saturates, so it never returns to zero
                        // and "no error yet" is simply err_count == 0.
                        if (err_count_q != '1) begin
                            err_count_n = err_count_q + (ADDR_W+1)'(1);
                        end
                        if (err_count_q == '0) begin
                            first_err_n = step_q;
                        end
                        err_flag_n = 1'b1;
                    end
                    if (last_step) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        i_n     = 1'b0;
                        s_n     = 1'b0;
                    end else begin
                        step_n = step_plus;
                        i_n    = next_entry[3];
                        s_n    = next_entry[2];
                    end
                end else begin
                    hold_n = hold_q + 8'd1;
                end
            end

            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                i_n     = 1'b0;
                s_n     = 1'b0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers. Reset holds the Moore machine in reset and
    // aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            hold_q      <= '0;
            steps_q     <= '0;
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dut_reset_q <= 1'b1;
            i_q         <= 1'b0;
            s_q         <= 1'b0;
        end else begin
            state_q     <= state_n;
            step_q      <= step_n;
            hold_q      <= hold_n;
            steps_q     <= steps_n;
            err_count_q <= err_count_n;
            err_flag_q  <= err_flag_n;
            first_err_q <= first_err_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            dut_reset_q <= dut_reset_n;
            i_q         <= i_n;
            s_q         <= s_n;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dut_reset = dut_reset_q;
    assign bus.I         = i_q;
    assign bus.S         = s_q;
    assign bus.err_count = err_count_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.first_err = first_err_q;

endmodule

// File: doc/moore_stim_sequencer.md
# moore_stim_sequencer

Programmable stimulus/check sequencer for the two-input Moore state machine (inputs I, S; outputs Q_1, Q_0). Replaces the free-running signal generator in the simulation top: it holds a small script of steps, each an (I, S) input pair plus the expected (Q_1, Q_0), and applies the script to the Moore machine after resetting it. It compares the machine's outputs at the end of each step and reports an error count and the first failing step.

## Interface
- DEPTH, 16, number of script entries (power of two, 2..256)
- ADDR_W, 4, log2(DEPTH)
- HOLD_CYCLES, 4, clock cycles each step's (I, S) is held; legal range 2..255
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high; clears all state below
- wr_en  in  1  script write strobe; ignored while busy=1
- wr_addr  in  ADDR_W  script entry index
- wr_data  in  4  {I, S, expQ_1, expQ_0} for that entry
- num_steps  in  ADDR_W+1  steps to run, sampled on accepted start; values >DEPTH clamp to DEPTH
- start  in  1  one-cycle request; accepted only in IDLE
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse at end of run
- dut_reset  out  1  reset drive to the Moore machine
- I, S  out  1 each  stimulus to the Moore machine
- Q_1, Q_0  in  1 each  Moore machine outputs
- err_count  out  ADDR_W+1  mismatching steps in last run
- err_flag  out  1  err_count != 0
- first_err  out  ADDR_W  index of first mismatching step; 0 if none

## Operation
- Script RAM: DEPTH x 4 bits, written one entry per cycle when wr_en=1 and state=IDLE. Contents are not cleared by Reset.
- States: IDLE, RST_DUT, APPLY, DONE.
- IDLE: busy=0, I=S=0, dut_reset=0. start=1 latches num_steps (clamped), clears err_count, err_flag and first_err, then goes to RST_DUT.
- RST_DUT: exactly 1 cycle, dut_reset=1. Go to APPLY with step=0, or to DONE if num_steps=0.
- APPLY: I, S are driven from entry[step] for HOLD_CYCLES cycles; hold counter runs 0..HOLD_CYCLES-1.
  - On the last hold cycle, sample {Q_1, Q_0} and compare with {expQ_1, expQ_0}.
  - On mismatch, err_count increments, saturating at all ones. If this is the first mismatch, first_err is set to step.
  - Then step increments; go to DONE when step+1 = num_steps, else stay in APPLY.
- DONE: 1 cycle, done=1, busy=1, I=S=0. Returns to IDLE.
- Result registers hold their values until the next accepted start or Reset.
- start during busy is ignored (not queued). wr_en during busy is ignored (RAM unchanged).

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, dut_reset=1 while Reset=1 (and 0 from the first cycle after Reset deasserts), I=0, S=0, err_count=0, err_flag=0, first_err=0. State returns to IDLE.
- Reset mid-run aborts immediately: no done pulse, results cleared.
- start accepted at edge t:
  - busy=1 and dut_reset=1 from cycle t+1.
  - Step 0 drives I, S from cycle t+2.
  - Step k occupies cycles t+2+k*HOLD_CYCLES .. t+1+(k+1)*HOLD_CYCLES.
- Compare point: last cycle of each step. The Moore machine registers the new (I, S) at the end of the first hold cycle, so its Q is settled at the compare point because HOLD_CYCLES>=2.
- done pulse is at cycle t+2+num_steps*HOLD_CYCLES; busy falls the cycle after.
- num_steps=0: done at t+2, err_count=0.
- Total run length is 2+N*HOLD_CYCLES cycles, plus the DONE cycle.
- A script write in cycle c is visible to a start accepted at c+1.

## Test plan
- Reset held 3 cycles, then released → busy=0, done=0, I=S=0, err_count=0; dut_reset=1 during Reset and 0 after.
- Load 4 entries whose expected Q match the Moore machine's true response (derived from its state diagram); num_steps=4, HOLD_CYCLES=4; start → dut_reset pulse 1 cycle after start, done exactly 18 cycles after start, err_count=0, err_flag=0.
- Same script with entry 2 expected Q inverted, plus entry 3 corrupted → err_count=2, first_err=2, err_flag=1.
- num_steps=0 → done 2 cycles after start, err_count=0. num_steps=20 with DEPTH=16 → runs 16 steps.
- start and wr_en pulsed mid-run → run length unchanged, RAM entry unchanged; a later run gives the same results.
- Reset asserted during step 1 → next cycle busy=0, I=S=0, no done pulse, results 0; a new start then completes normally.
